// File: rtl/barrett_pkg.sv
// Shared definitions for the Barrett reduction stream pipeline.
// Holds width defaults, the pipeline latency and the stage bundle.
package barrett_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_TAG_W = 8;
    localparam int LATENCY   = 4;

    localparam int X_W = 2 * DEF_WIDTH;
    // floor(x >> (k-1)) * mu can reach 2^(2k+2), so products keep
    // two bits above 2*WIDTH.
    localparam int Q_W = 2 * DEF_WIDTH + 2;
    // r = x - q3*m lies in [0, 3m); 3m can exceed 2^(k+1) when m is
    // close to 2^k, so the remainder keeps k+2 bits.
    localparam int R_W = DEF_WIDTH + 2;

    typedef struct packed {
        logic                 valid;
        logic [X_W-1:0]       x;
        logic [Q_W-1:0]       q;
        logic [R_W-1:0]       r;
        logic [DEF_TAG_W-1:0] tag;
    } stage_t;

endpackage

// File: rtl/barrett_corr.sv
// Final Barrett correction: up to two conditional subtractions of m.
// Ports: r (remainder, < 3m), m (modulus), res (r mod m).
module barrett_corr
    import barrett_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH+1:0] r,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] res
);

    logic [WIDTH+1:0] m_x;
    logic [WIDTH+1:0] r1;
    logic [WIDTH+1:0] r2;

    always_comb begin
        m_x = {2'b00, m};
        r1  = (r >= m_x) ? r - m_x : r;
        r2  = (r1 >= m_x) ? r1 - m_x : r1;
        res = r2[WIDTH-1:0];
    end

    logic unused_hi;
    assign unused_hi = ^r2[WIDTH+1:WIDTH];

endmodule

// File: rtl/barrett_stream.sv
// Streaming Barrett reduction x mod m, four register stages, one op/cycle.
// Ports: clk_i, rst_ni; cfg_* loads m/mu/k when the pipe is empty;
// in_* / x_i / tag_i operand stream; out_* / result_o / tag_o results.
// Stage storage uses the package stage bundle sized by the defaults.
module barrett_stream
    import barrett_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TAG_W = DEF_TAG_W,
    localparam int K_W  = $clog2(WIDTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cfg_valid_i,
    output logic               cfg_ready_o,
    input  logic [WIDTH-1:0]   cfg_m_i,
    input  logic [WIDTH:0]     cfg_mu_i,
    input  logic [K_W-1:0]     cfg_k_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [2*WIDTH-1:0] x_i,
    input  logic [TAG_W-1:0]   tag_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [WIDTH-1:0]   result_o,
    output logic [TAG_W-1:0]   tag_o
);

    stage_t s1;
    stage_t s2;
    stage_t s3;

    logic [WIDTH-1:0] m_q;
    logic [WIDTH:0]   mu_q;
    logic [K_W-1:0]   k_q;

    logic en;
    logic busy;
    logic cfg_fire;
    logic in_fire;

    // One enable for the whole pipe: it advances whenever the output
    // register is empty or being drained.
    assign en          = !out_valid_o || out_ready_i;
    assign busy        = s1.valid || s2.valid || s3.valid || out_valid_o;
    assign cfg_ready_o = !busy && !in_valid_i;
    // A pending configuration blocks operands so it can win the slot.
    assign in_ready_o  = en && !cfg_valid_i;
    assign cfg_fire    = cfg_valid_i && cfg_ready_o;
    assign in_fire     = in_valid_i && in_ready_o;

    logic [2*WIDTH-1:0] x_sh;
    logic [Q_W-1:0]     q2;
    logic [Q_W-1:0]     q3;
    logic [Q_W-1:0]     p;
    logic [X_W-1:0]     diff;
    logic [R_W-1:0]     r_mask;
    logic [R_W-1:0]     r;
    logic [WIDTH-1:0]   res;

    always_comb begin
        x_sh   = x_i >> (k_q - K_W'(1));
        q2     = Q_W'(x_sh) * Q_W'(mu_q);
        q3     = s1.q >> (k_q + K_W'(1));
        p      = q3 * Q_W'(m_q);
        diff   = s2.x - s2.q[X_W-1:0];
        r_mask = ~({R_W{1'b1}} << (k_q + K_W'(2)));
        r      = diff[R_W-1:0] & r_mask;
    end

    barrett_corr #(
        .WIDTH(WIDTH)
    ) u_corr (
        .r  (s3.r),
        .m  (m_q),
        .res(res)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1          <= '0;
            s2          <= '0;
            s3          <= '0;
            out_valid_o <= 1'b0;
            result_o    <= '0;
            tag_o       <= '0;
            m_q         <= '0;
            mu_q        <= '0;
            k_q         <= '0;
        end else begin
            if (cfg_fire) begin
                m_q  <= cfg_m_i;
                mu_q <= cfg_mu_i;
                k_q  <= cfg_k_i;
            end
            if (en) begin
                s1.valid    <= in_fire;
                s1.x        <= x_i;
                s1.q        <= q2;
                s1.r        <= '0;
                s1.tag      <= tag_i;
                s2.valid    <= s1.valid;
                s2.x        <= s1.x;
                s2.q        <= p;
                s2.r        <= '0;
                s2.tag      <= s1.tag;
                s3.valid    <= s2.valid;
                s3.x        <= '0;
                s3.q        <= '0;
                s3.r        <= r;
                s3.tag      <= s2.tag;
                out_valid_o <= s3.valid;
                if (s3.valid) begin
                    result_o <= res;
                    tag_o    <= s3.tag;
                end
            end
        end
    end

    logic unused_ok;
    assign unused_ok = ^{s1.r, s2.r, s3.x, s3.q,
                         s2.q[Q_W-1:X_W], diff[X_W-1:R_W]};

endmodule

// File: tb/tb_barrett_stream.sv
// Scoreboard bench for barrett_stream: golden model is x % m.
// Covers directed vectors, random streams, backpressure, cfg and reset.
module tb_barrett_stream;
    import barrett_pkg::*;

    localparam int W = 64;
    localparam int T = 8;

    logic           clk;
    logic           rst_n;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [W-1:0]   cfg_m;
    logic [W:0]     cfg_mu;
    logic [6:0]     cfg_k;
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] x_in;
    logic [T-1:0]   tag_in;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   result;
    logic [T-1:0]   tag_out;

    barrett_stream #(
        .WIDTH(W),
        .TAG_W(T)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .cfg_valid_i(cfg_valid),
        .cfg_ready_o(cfg_ready),
        .cfg_m_i    (cfg_m),
        .cfg_mu_i   (cfg_mu),
        .cfg_k_i    (cfg_k),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .x_i        (x_in),
        .tag_i      (tag_in),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .result_o   (result),
        .tag_o      (tag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic [T-1:0] tag;
        int           cyc;
        bit           lat;
    } exp_t;

    exp_t         sb[$];
    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    logic [W-1:0] mm       = '0;
    bit           rand_rdy = 1'b0;
    bit           prev_stall = 1'b0;
    logic [W-1:0] prev_res;
    logic [T-1:0] prev_tag;

    task automatic chk(input bit ok, input string name,
                       input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: all sampling on the falling edge, where the values seen
    // are the ones the next rising edge will act on.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk(out_valid, "stall_valid", out_valid, 1);
                chk(result == prev_res, "stall_result", result, prev_res);
                chk(tag_out == prev_tag, "stall_tag", tag_out, prev_tag);
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = result;
            prev_tag   = tag_out;
            chk(cfg_ready == (sb.size() == 0 && !in_valid), "cfg_ready",
                cfg_ready, (sb.size() == 0 && !in_valid));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "spurious_out", result, 0);
                end else begin
                    e = sb.pop_front();
                    chk(result == e.res, "result", result, e.res);
                    chk(tag_out == e.tag, "tag", tag_out, e.tag);
                    if (e.lat)
                        chk(cyc - e.cyc == LATENCY, "latency",
                            cyc - e.cyc, LATENCY);
                end
            end
            if (cfg_valid && cfg_ready) mm = cfg_m;
            if (in_valid && in_ready) begin
                e.res = W'(x_in % {64'b0, mm});
                e.tag = tag_in;
                e.cyc = cyc;
                e.lat = !rand_rdy;
                sb.push_back(e);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic configure(input logic [W-1:0] m, input logic [W:0] mu,
                             input logic [6:0] k);
        bit acc;
        cfg_valid = 1'b1;
        cfg_m     = m;
        cfg_mu    = mu;
        cfg_k     = k;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            acc = cfg_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            if (n >= 500) begin
                chk(1'b0, "cfg_timeout", n, 0);
                break;
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic send(input logic [2*W-1:0] x, input logic [T-1:0] t);
        bit acc;
        in_valid = 1'b1;
        x_in     = x;
        tag_in   = t;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            if (n >= 200) begin
                chk(1'b0, "send_timeout", n, 0);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 3000 && sb.size() != 0; n++) @(posedge clk);
        chk(sb.size() == 0, "drain", sb.size(), 0);
        idle(2);
    endtask

    task automatic rand_cfg(output logic [W-1:0] m, output logic [W:0] mu,
                            output logic [6:0] k);
        logic [W-1:0] mask;
        logic [129:0] t2k;
        int           kk;
        kk   = $urandom_range(2, 64);
        mask = (kk == 64) ? '1 : ((64'd1 << kk) - 64'd1);
        m    = {$urandom, $urandom} & mask;
        m    = m | (64'd1 << (kk - 1)) | 64'd1;
        t2k  = 130'd1 << (2 * kk);
        mu   = (W + 1)'(t2k / {66'b0, m});
        k    = 7'(kk);
    endtask

    function automatic logic [2*W-1:0] rand_x(input int k);
        logic [2*W-1:0] x;
        logic [2*W-1:0] mask;
        x    = {$urandom, $urandom, $urandom, $urandom};
        mask = (k == 64) ? '1 : ((128'd1 << (2 * k)) - 128'd1);
        return x & mask;
    endfunction

    logic [W-1:0]   rm;
    logic [W:0]     rmu;
    logic [6:0]     rk;
    logic [2*W-1:0] m2;
    int             pulses;

    initial begin
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_m     = '0;
        cfg_mu    = '0;
        cfg_k     = '0;
        in_valid  = 1'b0;
        x_in      = '0;
        tag_in    = '0;
        out_ready = 1'b1;
        idle(3);
        chk(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
        chk(result == '0, "rst_result", result, 0);
        chk(tag_out == '0, "rst_tag", tag_out, 0);
        rst_n = 1'b1;
        idle(1);
        chk(in_ready == 1'b1, "rst_in_ready", in_ready, 1);
        chk(cfg_ready == 1'b1, "rst_cfg_ready", cfg_ready, 1);

        configure(64'd13, 65'd19, 7'd4);
        send(128'd255, 8'h01);
        send(128'd200, 8'h02);
        send(128'd13, 8'h03);
        send(128'd12, 8'h04);
        drain();

        cfg_valid = 1'b1;
        cfg_m     = 64'd7;
        cfg_mu    = 65'd9;
        cfg_k     = 7'd3;
        in_valid  = 1'b1;
        x_in      = 128'd99;
        tag_in    = 8'h55;
        @(negedge clk);
        chk(in_ready == 1'b0, "cfg_priority_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        configure(64'd7, 65'd9, 7'd3);
        send(128'd50, 8'h56);
        drain();

        configure(64'hFFFF_FFFF_FFFF_FFC5, 65'h1_0000_0000_0000_003B, 7'd64);
        send('1, 8'h10);
        drain();

        m2 = {64'b0, mm} * {64'b0, mm};
        for (int i = 0; i < 1000; i++)
            send({$urandom, $urandom, $urandom, $urandom} % m2, 8'(i));
        drain();

        rand_rdy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            rand_cfg(rm, rmu, rk);
            configure(rm, rmu, rk);
            for (int i = 0; i < 150; i++) begin
                send(rand_x(int'(rk)), 8'(i + 32 * c));
                if ($urandom_range(0, 3) == 0) idle(1);
            end
            drain();
        end
        rand_rdy = 1'b0;
        idle(2);

        configure(64'd13, 65'd19, 7'd4);
        send(128'd100, 8'h21);
        send(128'd101, 8'h22);
        send(128'd102, 8'h23);
        @(negedge clk);
        chk(cfg_ready == 1'b0, "cfg_busy", cfg_ready, 0);
        @(posedge clk);
        #1;
        configure(64'd7, 65'd9, 7'd3);
        send(128'd50, 8'h24);
        drain();

        for (int i = 0; i < 5; i++) send(128'(200 + i), 8'(64 + i));
        #1;
        rst_n = 1'b0;
        #1;
        chk(out_valid == 1'b0, "midrst_out_valid", out_valid, 0);
        chk(result == '0, "midrst_result", result, 0);
        chk(tag_out == '0, "midrst_tag", tag_out, 0);
        sb.delete();
        mm = '0;
        idle(2);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        chk(pulses == 0, "no_stale_out", pulses, 0);
        chk(in_ready == 1'b1, "post_rst_in_ready", in_ready, 1);
        chk(cfg_ready == 1'b1, "post_rst_cfg_ready", cfg_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
